// File: rtl/goomba_contact_judge_pkg.sv
// rtl/goomba_contact_judge_pkg.sv - shared goomba/Mario constants, state encoding and geometry helper
package goomba_contact_judge_pkg;

  // Sprite extents; the Mario pair is shared with the Mario display block.
  localparam int GOOMBA_WIDTH  = 26;
  localparam int GOOMBA_HEIGHT = 27;
  localparam int MARIO_WIDTH   = 26;
  localparam int MARIO_HEIGHT  = 31;

  localparam int POS_W  = 10;
  localparam int GEOM_W = 11;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_SQUASH = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  // Far edge of a box, widened so edges near the screen limit never wrap.
  function automatic logic [GEOM_W-1:0] box_extent(input logic [POS_W-1:0] pos, input int size);
    return {1'b0, pos} + GEOM_W'(size);
  endfunction

endpackage

// File: rtl/goomba_contact_judge_if.sv
// rtl/goomba_contact_judge_if.sv - frame-rate contact bus between game blocks and the contact judge
interface goomba_contact_judge_if;

  logic       frame_tick;
  logic [9:0] mario_left;
  logic [9:0] mario_top;
  logic       mario_falling;
  logic [9:0] goomba_left;
  logic [9:0] goomba_top;
  logic       respawn;

  logic       goomba_alive;
  logic       squash_on;
  logic       stomp_pulse;
  logic       hurt_pulse;
  logic       invuln;

  modport master (
    output frame_tick, mario_left, mario_top, mario_falling,
           goomba_left, goomba_top, respawn,
    input  goomba_alive, squash_on, stomp_pulse, hurt_pulse, invuln
  );

  modport slave (
    input  frame_tick, mario_left, mario_top, mario_falling,
           goomba_left, goomba_top, respawn,
    output goomba_alive, squash_on, stomp_pulse, hurt_pulse, invuln
  );

endinterface

// File: rtl/goomba_contact_judge_box_overlap.sv
// rtl/goomba_contact_judge_box_overlap.sv - inclusive axis-aligned box overlap test on 11-bit extents
module goomba_contact_judge_box_overlap
  import goomba_contact_judge_pkg::*;
(
  input  logic [GEOM_W-1:0] a_left,
  input  logic [GEOM_W-1:0] a_right,
  input  logic [GEOM_W-1:0] a_top,
  input  logic [GEOM_W-1:0] a_bottom,
  input  logic [GEOM_W-1:0] b_left,
  input  logic [GEOM_W-1:0] b_right,
  input  logic [GEOM_W-1:0] b_top,
  input  logic [GEOM_W-1:0] b_bottom,
  output logic              hit
);

  logic x_hit;
  logic y_hit;

  assign x_hit = (a_left <= b_right) && (b_left <= a_right);
  assign y_hit = (a_top <= b_bottom) && (b_top <= a_bottom);
  assign hit   = x_hit && y_hit;

endmodule

// File: rtl/goomba_contact_judge.sv
// rtl/goomba_contact_judge.sv - per-frame stomp/hurt decision, goomba life cycle and Mario invulnerability
module goomba_contact_judge
  import goomba_contact_judge_pkg::*;
#(
  parameter int STOMP_MARGIN  = 8,
  parameter int SQUASH_FRAMES = 30,
  parameter int IFRAMES       = 60
) (
  input  logic                    clk,
  input  logic                    rst,
  goomba_contact_judge_if.slave   bus
);

  localparam int SQ_W = $clog2(SQUASH_FRAMES);
  localparam int IF_W = $clog2(IFRAMES);
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQUASH_FRAMES - 1);
  localparam logic [IF_W-1:0] IF_LAST = IF_W'(IFRAMES - 1);

  logic [GEOM_W-1:0] m_left;
  logic [GEOM_W-1:0] m_right;
  logic [GEOM_W-1:0] m_top;
  logic [GEOM_W-1:0] m_bottom;
  logic [GEOM_W-1:0] g_left;
  logic [GEOM_W-1:0] g_right;
  logic [GEOM_W-1:0] g_top;
  logic [GEOM_W-1:0] g_bottom;
  logic [GEOM_W-1:0] g_stomp_line;

  logic overlap;
  logic stomp_cond;
  logic hurt_cond;
  logic stomp_evt;
  logic hurt_evt;

  state_t          state;
  state_t          state_next;
  logic [SQ_W-1:0] squash_cnt;
  logic [IF_W-1:0] iframe_cnt;
  logic            invuln_q;
  logic            stomp_q;
  logic            hurt_q;

  assign m_left       = {1'b0, bus.mario_left};
  assign m_right      = box_extent(bus.mario_left, MARIO_WIDTH);
  assign m_top        = {1'b0, bus.mario_top};
  assign m_bottom     = box_extent(bus.mario_top, MARIO_HEIGHT);
  assign g_left       = {1'b0, bus.goomba_left};
  assign g_right      = box_extent(bus.goomba_left, GOOMBA_WIDTH);
  assign g_top        = {1'b0, bus.goomba_top};
  assign g_bottom     = box_extent(bus.goomba_top, GOOMBA_HEIGHT);
  assign g_stomp_line = box_extent(bus.goomba_top, STOMP_MARGIN);

  goomba_contact_judge_box_overlap u_box_overlap (
    .a_left   (m_left),
    .a_right  (m_right),
    .a_top    (m_top),
    .a_bottom (m_bottom),
    .b_left   (g_left),
    .b_right  (g_right),
    .b_top    (g_top),
    .b_bottom (g_bottom),
    .hit      (overlap)
  );

  // Stomp only needs Mario's feet to land within the margin while descending.
  assign stomp_cond = overlap && bus.mario_falling && (m_bottom <= g_stomp_line);
  assign hurt_cond  = overlap && !stomp_cond && !invuln_q;

  assign stomp_evt = bus.frame_tick && (state == ST_ALIVE) && stomp_cond;
  assign hurt_evt  = bus.frame_tick && (state == ST_ALIVE) && hurt_cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ALIVE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ALIVE: begin
        if (stomp_evt) begin
          state_next = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        if (bus.frame_tick && (squash_cnt == SQ_LAST)) begin
          state_next = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (bus.respawn) begin
          state_next = ST_ALIVE;
        end
      end
      default: begin
        state_next = ST_ALIVE;
      end
    endcase
  end

  always_comb begin
    bus.goomba_alive = 1'b0;
    bus.squash_on    = 1'b0;
    case (state)
      ST_ALIVE:  bus.goomba_alive = 1'b1;
      ST_SQUASH: bus.squash_on    = 1'b1;
      default: begin
        bus.goomba_alive = 1'b0;
        bus.squash_on    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stomp_q    <= 1'b0;
      hurt_q     <= 1'b0;
      squash_cnt <= '0;
      iframe_cnt <= '0;
      invuln_q   <= 1'b0;
    end else begin
      stomp_q <= stomp_evt;
      hurt_q  <= hurt_evt;

      if (stomp_evt) begin
        squash_cnt <= '0;
      end else if (bus.frame_tick && (state == ST_SQUASH) && (squash_cnt != SQ_LAST)) begin
        squash_cnt <= squash_cnt + 1'b1;
      end

      // A hurt can only start a window; one already running is never restarted.
      if (hurt_evt) begin
        invuln_q   <= 1'b1;
        iframe_cnt <= '0;
      end else if (bus.frame_tick && invuln_q) begin
        if (iframe_cnt == IF_LAST) begin
          invuln_q <= 1'b0;
        end else begin
          iframe_cnt <= iframe_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.stomp_pulse = stomp_q;
  assign bus.hurt_pulse  = hurt_q;
  assign bus.invuln      = invuln_q;

endmodule

// File: tb/tb_goomba_contact_judge.sv
// tb/tb_goomba_contact_judge.sv - scoreboard bench for goomba_contact_judge
module tb_goomba_contact_judge;

  typedef struct packed {
    logic stomp;
    logic hurt;
    logic alive;
    logic squash;
    logic inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  goomba_contact_judge_if bus();

  goomba_contact_judge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  // Each driven cycle leaves one expectation for the state seen after its edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stomp_pulse",  bus.stomp_pulse,  e.stomp);
      chk("hurt_pulse",   bus.hurt_pulse,   e.hurt);
      chk("goomba_alive", bus.goomba_alive, e.alive);
      chk("squash_on",    bus.squash_on,    e.squash);
      chk("invuln",       bus.invuln,       e.inv);
    end
  end

  task automatic cyc(input logic tk, input logic rsp, input logic es, input logic eh,
                     input logic ea, input logic esq, input logic ei);
    @(negedge clk);
    bus.frame_tick = tk;
    bus.respawn    = rsp;
    exp_q.push_back({es, eh, ea, esq, ei});
  endtask

  task automatic tick(input logic es, input logic eh, input logic ea, input logic esq, input logic ei);
    cyc(1'b1, 1'b0, es, eh, ea, esq, ei);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, ea, esq, ei);
  endtask

  task automatic quiet_ticks(input int n, input logic ea, input logic esq, input logic ei);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, ea, esq, ei);
    end
  endtask

  task automatic pos(input int ml, input int mt, input logic fall, input int gl, input int gt);
    bus.mario_left    = 10'(ml);
    bus.mario_top     = 10'(mt);
    bus.mario_falling = fall;
    bus.goomba_left   = 10'(gl);
    bus.goomba_top    = 10'(gt);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_alive"},  bus.goomba_alive, 1'b1);
    chk({tag, "_squash"}, bus.squash_on,    1'b0);
    chk({tag, "_stomp"},  bus.stomp_pulse,  1'b0);
    chk({tag, "_hurt"},   bus.hurt_pulse,   1'b0);
    chk({tag, "_invuln"}, bus.invuln,       1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.respawn    = 1'b0;
    pos(400, 50, 1'b0, 100, 200);
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Overlap without a frame tick produces nothing.
    pos(100, 170, 1'b1, 100, 200);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Stomp, squash for 30 ticks (respawn ignored mid-squash), then dead.
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    quiet_ticks(10, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    quiet_ticks(19, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet_ticks(2, 1'b0, 1'b0, 1'b0);
    pos(400, 50, 1'b0, 100, 200);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Side hit, 60-tick window with suppressed hurts, then hurt again.
    pos(80, 200, 1'b0, 100, 200);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    quiet_ticks(59, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    pos(400, 50, 1'b0, 100, 200);
    quiet_ticks(59, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Right-edge inclusivity: 126 touches, 127 misses.
    pos(126, 200, 1'b0, 100, 200);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    pos(400, 50, 1'b0, 100, 200);
    quiet_ticks(59, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pos(127, 200, 1'b0, 100, 200);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Stomp margin: bottom 208 stomps, bottom 209 hurts.
    pos(100, 177, 1'b1, 100, 200);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pos(400, 50, 1'b0, 100, 200);
    quiet_ticks(29, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pos(100, 178, 1'b1, 100, 200);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Stomp is still allowed while invulnerable and leaves the window running.
    pos(100, 170, 1'b1, 100, 200);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    quiet_ticks(5, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-squash and mid-window, sampled before any edge.
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Invulnerability was cleared, so a fresh contact hurts at once.
    pos(80, 200, 1'b0, 100, 200);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    bus.frame_tick = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #3;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
